// File: rtl/reflet_timer_mc.sv
// rtl/reflet_timer_mc.sv - multi-channel prescaled down-counting timer with bus registers; one-shot mode via REFLET_TIMER_ONESHOT_EN
module reflet_timer_mc #(
    parameter int                        wordsize       = 16,
    parameter int                        base_addr_size = 16,
    parameter logic [base_addr_size-1:0] base_addr      = 16'hFF10,
    parameter int                        channels       = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [base_addr_size-1:0] addr,
    input  logic                      write_en,
    input  logic [wordsize-1:0]       data_in,
    output logic [wordsize-1:0]       data_out,
    output logic                      interrupt
);
    // One extra bit so the window end cannot wrap at the top of the address space
    localparam int AW = base_addr_size + 1;
    localparam logic [AW-1:0] base_x  = {1'b0, base_addr};
    localparam logic [AW-1:0] limit_x = base_x + AW'(4 * channels);

    logic [AW-1:0]       addr_x;
    logic                hit;
    logic [3:0]          offset;
    logic [1:0]          reg_sel;
    logic [channels-1:0] ch_sel;

    logic [channels-1:0] run;
    logic [channels-1:0] oneshot;
    logic [channels-1:0] irq_en;
    logic [channels-1:0] irq_flag;
    logic [wordsize-1:0] pre_q    [channels];
    logic [wordsize-1:0] reload_q [channels];
    logic [wordsize-1:0] count_q  [channels];
    logic [wordsize-1:0] psc_q    [channels];

    logic [channels-1:0] tick;
    logic [channels-1:0] expire;
    logic [channels-1:0] wr_ctrl;
    logic [channels-1:0] wr_pre;
    logic [channels-1:0] wr_reload;

    assign addr_x  = {1'b0, addr};
    assign hit     = enable && (addr_x >= base_x) && (addr_x < limit_x);
    assign offset  = 4'(addr - base_addr);
    assign reg_sel = offset[1:0];

`ifndef REFLET_TIMER_ONESHOT_EN
    // Without the one-shot option every channel is periodic
    assign oneshot = '0;
`endif

    // Channel select, write strobes and per-channel tick/expiry conditions
    always_comb begin
        ch_sel    = '0;
        tick      = '0;
        expire    = '0;
        wr_ctrl   = '0;
        wr_pre    = '0;
        wr_reload = '0;
        for (int i = 0; i < channels; i++) begin
            ch_sel[i]    = hit && (offset[3:2] == 2'(i));
            tick[i]      = run[i] && (psc_q[i] == pre_q[i]);
            expire[i]    = tick[i] && (count_q[i] == '0);
            wr_ctrl[i]   = ch_sel[i] && write_en && (reg_sel == 2'd0);
            wr_pre[i]    = ch_sel[i] && write_en && (reg_sel == 2'd1);
            wr_reload[i] = ch_sel[i] && write_en && (reg_sel == 2'd2);
        end
    end

    // Counting, register writes and flag handling; later assignments take priority
    always_ff @(posedge clk) begin
        if (reset) begin
            run      <= '0;
            irq_en   <= '0;
            irq_flag <= '0;
`ifdef REFLET_TIMER_ONESHOT_EN
            oneshot  <= '0;
`endif
            for (int i = 0; i < channels; i++) begin
                pre_q[i]    <= '0;
                reload_q[i] <= '0;
                count_q[i]  <= '0;
                psc_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < channels; i++) begin
                if (run[i]) begin
                    psc_q[i] <= tick[i] ? '0 : psc_q[i] + 1'b1;
                    if (tick[i]) begin
                        if (!expire[i])
                            count_q[i] <= count_q[i] - 1'b1;
                        else if (oneshot[i])
                            run[i] <= 1'b0;
                        else
                            count_q[i] <= reload_q[i];
                    end
                end
                if (wr_ctrl[i]) begin
                    run[i]    <= data_in[0];
                    irq_en[i] <= data_in[2];
`ifdef REFLET_TIMER_ONESHOT_EN
                    oneshot[i] <= data_in[1];
`endif
                    // Start from a stopped state: reload the count, restart the prescaler
                    if (data_in[0] && !run[i]) begin
                        count_q[i] <= reload_q[i];
                        psc_q[i]   <= '0;
                    end
                    if (data_in[3])
                        irq_flag[i] <= 1'b0;
                end
                if (wr_pre[i]) begin
                    pre_q[i] <= data_in;
                    psc_q[i] <= '0;
                end
                if (wr_reload[i])
                    reload_q[i] <= data_in;
                // Hardware set wins over a same-cycle write-1 clear
                if (expire[i])
                    irq_flag[i] <= 1'b1;
            end
        end
    end

    // Combinational read mux; quiet during writes, misses and reset
    always_comb begin
        data_out = '0;
        for (int i = 0; i < channels; i++) begin
            if (ch_sel[i] && !write_en && !reset) begin
                case (reg_sel)
                    2'd0:    data_out = wordsize'({irq_flag[i], irq_en[i], oneshot[i], run[i]});
                    2'd1:    data_out = pre_q[i];
                    2'd2:    data_out = reload_q[i];
                    default: data_out = count_q[i];
                endcase
            end
        end
    end

    assign interrupt = !reset && |(irq_flag & irq_en);

endmodule

// File: tb/tb_reflet_timer_mc.sv
// tb/tb_reflet_timer_mc.sv - directed self-checking bench for reflet_timer_mc
module tb_reflet_timer_mc;
    localparam int B = 32'hFF10;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] addr;
    logic        write_en;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        interrupt;
    logic [15:0] d;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    reflet_timer_mc dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .addr      (addr),
        .write_en  (write_en),
        .data_in   (data_in),
        .data_out  (data_out),
        .interrupt (interrupt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int v);
        enable   = 1'b1;
        write_en = 1'b1;
        addr     = a[15:0];
        data_in  = v[15:0];
        step();
        enable   = 1'b0;
        write_en = 1'b0;
    endtask

    task automatic rd(input int a, output logic [15:0] v);
        enable   = 1'b1;
        write_en = 1'b0;
        addr     = a[15:0];
        #1;
        v        = data_out;
        enable   = 1'b0;
    endtask

    task automatic rchk(input string tag, input int a, input int exp);
        logic [15:0] v;
        rd(a, v);
        check(tag, {16'h0, v}, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; write_en = 1'b0; addr = '0; data_in = '0;
        step();
        step();
        reset = 1'b0;

        // Reset state and decode
        rchk("rst_ctrl0", B, 0);
        rchk("rst_count1", B + 7, 0);
        check("rst_irq", {31'h0, interrupt}, 0);
        wr(B + 2, 7);
        rchk("reload_rd", B + 2, 7);
        enable = 1'b0; addr = 16'(B + 2); #1;
        check("no_enable_rd", {16'h0, data_out}, 0);
        enable = 1'b1; write_en = 1'b1; #1;
        check("write_cycle_rd", {16'h0, data_out}, 0);
        enable = 1'b0; write_en = 1'b0;
        rchk("below_window", B - 1, 0);
`ifndef REFLET_TIMER_ONESHOT_EN
        wr(B, 2);
        rchk("oneshot_ro", B, 0);
`endif

        // Periodic: PRE=1 RELOAD=2 -> expiry every 6 cycles
        do_reset();
        wr(B + 1, 1);
        wr(B + 2, 2);
        wr(B, 5);
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("per_irq_%0d", k), {31'h0, interrupt}, (k == 6) ? 1 : 0);
        end
        wr(B, 16'hD);
        check("clr_irq", {31'h0, interrupt}, 0);
        for (int k = 8; k <= 12; k++) begin
            step();
            check($sformatf("per2_irq_%0d", k), {31'h0, interrupt}, (k == 12) ? 1 : 0);
        end
        wr(B, 16'hD);
        check("clr2_irq", {31'h0, interrupt}, 0);
        for (int k = 14; k <= 17; k++) step();
        wr(B, 16'hD);
        rchk("set_wins_ctrl", B, 16'hD);
        check("set_wins_irq", {31'h0, interrupt}, 1);
        wr(B, 16'hD);
        check("clr3_irq", {31'h0, interrupt}, 0);
        rchk("clr3_ctrl", B, 5);
        rchk("count_e19", B + 3, 2);
        wr(B, 0);
        rchk("stop_count", B + 3, 1);
        step(); step(); step();
        rchk("frozen_count", B + 3, 1);
        rchk("frozen_ctrl", B, 0);

        // Two independent channels
        do_reset();
        wr(B + 1, 0);
        wr(B + 2, 4);
        wr(B + 5, 2);
        wr(B + 6, 1);
        wr(B, 1);
        for (int k = 1; k <= 7; k++) begin
            if (k == 1) wr(B + 4, 1);
            else        step();
            rd(B, d);
            check($sformatf("ch0_flag_%0d", k), {31'h0, d[3]}, (k >= 5) ? 1 : 0);
            rd(B + 4, d);
            check($sformatf("ch1_flag_%0d", k), {31'h0, d[3]}, (k >= 7) ? 1 : 0);
            if (k == 2) rchk("ch1_count_k2", B + 7, 1);
            if (k == 5) rchk("ch1_count_k5", B + 7, 0);
        end
        check("indep_irq", {31'h0, interrupt}, 0);
        rchk("ch0_count_k7", B + 3, 2);

        // Reset mid-count overrides a concurrent write
        wr(B, 5);
        check("pre_rst_irq", {31'h0, interrupt}, 1);
        reset = 1'b1; enable = 1'b1; write_en = 1'b0; addr = 16'(B); #1;
        check("in_rst_dout", {16'h0, data_out}, 0);
        check("in_rst_irq", {31'h0, interrupt}, 0);
        write_en = 1'b1; addr = 16'(B + 2); data_in = 16'h9;
        step();
        write_en = 1'b0; enable = 1'b0; reset = 1'b0;
        for (int r = 0; r < 8; r++) rchk($sformatf("post_rst_r%0d", r), B + r, 0);
        check("post_rst_irq", {31'h0, interrupt}, 0);
        wr(B + 3, 16'h55);
        rchk("count_ro", B + 3, 0);

`ifdef REFLET_TIMER_ONESHOT_EN
        // One-shot: single expiry after 4 cycles
        do_reset();
        wr(B + 1, 0);
        wr(B + 2, 3);
        wr(B, 3);
        for (int k = 1; k <= 4; k++) begin
            step();
            rd(B, d);
            check($sformatf("os_flag_%0d", k), {31'h0, d[3]}, (k == 4) ? 1 : 0);
        end
        rchk("os_ctrl", B, 16'hA);
        rchk("os_count", B + 3, 0);
        wr(B, 16'hA);
        for (int k = 0; k < 6; k++) begin
            step();
            rd(B, d);
            check($sformatf("os_noflag_%0d", k), {31'h0, d[3]}, 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/reflet_timer_mc.md
REFLET_TIMER_MC -- requirements
Module: reflet_timer_mc

Interface
REQ-001 SHALL have parameter wordsize, default 16, data bus width and counter width.
REQ-002 SHALL have parameter base_addr_size, default 16, address bus width.
REQ-003 SHALL have parameter base_addr, default 16'hFF10, address of channel 0 CTRL.
REQ-004 SHALL have parameter channels, default 2, legal 1..4, number of independent timer channels.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port enable  input  1  bus select; no register access when low.
REQ-008 SHALL have port addr  input  base_addr_size  system bus address.
REQ-009 SHALL have port write_en  input  1  write strobe, qualified by enable and address hit.
REQ-010 SHALL have port data_in  input  wordsize  write data.
REQ-011 SHALL have port data_out  output  wordsize  read data, combinational.
REQ-012 SHALL have port interrupt  output  1  OR over channels of (IRQ_FLAG & IRQ_EN), level.

Function
REQ-013 SHALL decode hit = enable & base_addr <= addr < base_addr + 4*channels; offset = addr - base_addr; channel = offset/4; register = offset mod 4.
REQ-014 SHALL map per channel: 0 CTRL (rw), 1 PRE (rw), 2 RELOAD (rw), 3 COUNT (read-only, writes ignored).
REQ-015 SHALL define CTRL bits: [0] RUN, [1] ONESHOT, [2] IRQ_EN, [3] IRQ_FLAG (reads flag; writing 1 clears, 0 no effect); other bits read 0.
REQ-016 SHALL drive data_out with the addressed register when hit & !write_en, else 0.
REQ-017 SHALL, on a write setting RUN from 0 to 1, load COUNT <= RELOAD and prescaler counter <= 0 on that edge.
REQ-018 SHALL, while RUN=1, increment the prescaler each cycle; when it equals PRE it wraps to 0 and asserts a tick that cycle.
REQ-019 SHALL, on tick with COUNT != 0, decrement COUNT; on tick with COUNT == 0, expire.
REQ-020 SHALL on expiry set IRQ_FLAG; periodic: COUNT <= RELOAD; one-shot: RUN <= 0, COUNT stays 0.
REQ-021 SHALL give expiry period (PRE+1)*(RELOAD+1) cycles; first expiry exactly that many cycles after the RUN-setting edge.
REQ-022 SHALL treat PRE=0 as tick every cycle and RELOAD=0 as expiry every tick.
REQ-023 SHALL apply a RELOAD write while running only at the next reload; a PRE write SHALL reset the prescaler counter to 0.
REQ-024 SHALL, when RUN cleared by write, freeze COUNT and prescaler; IRQ_FLAG unaffected.
REQ-025 SHALL give hardware set priority over write-1 clear of IRQ_FLAG in the same cycle.
REQ-026 SHALL keep channels fully independent; interrupt asserts the cycle after the flag-setting edge (registered flag).

Reset
REQ-027 SHALL, on reset=1 at a clk edge, clear all CTRL, PRE, RELOAD, COUNT, prescaler counters to 0; interrupt = 0 next cycle; reset overrides any concurrent write, including mid-count.
REQ-028 SHALL output data_out = 0 and interrupt = 0 while in reset.

Configuration
REQ-029 SHALL, with macro REFLET_TIMER_ONESHOT_EN defined, implement CTRL[1] per REQ-020.
REQ-030 SHALL, without REFLET_TIMER_ONESHOT_EN, hardwire CTRL[1] to read 0, ignore writes, and always run periodic.

Verification
REQ-031 SHALL cover: ch0 PRE=1, RELOAD=2, IRQ_EN=1, RUN=1 -> interrupt high exactly 6 cycles after RUN write, flag re-sets every 6 cycles.
REQ-032 SHALL cover: write CTRL=0x8 the cycle flag sets -> flag remains 1; write 0x8 next cycle -> interrupt low.
REQ-033 SHALL cover (macro defined): ONESHOT PRE=0, RELOAD=3 -> single expiry at cycle 4, RUN reads 0, COUNT 0, no further flags.
REQ-034 SHALL cover: channels=2, ch0 PRE=0 RELOAD=4, ch1 PRE=2 RELOAD=1 -> flags at 5 and 6 cycles resp., independent; ch1 COUNT read at base_addr+7.
REQ-035 SHALL cover: reset pulse mid-count, then read all registers -> all 0, interrupt 0; write to COUNT -> read still 0.
